firebird7_in_gate1_tessent_data_tdr_w19: RTL and testbench
==========================================================

FIREBIRD7_IN_GATE1_TESSENT_DATA_TDR_W19 -- requirements
Module: firebird7_in_gate1_tessent_data_tdr_w19

Interface
REQ-001 SHALL have parameter WIDTH, default 19, giving the override/observe data width.
REQ-002 SHALL have port ijtag_tck, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port ijtag_reset, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port ijtag_sel, input, 1, TDR selected by the SIB/host network.
REQ-005 SHALL have port ijtag_ce, input, 1, capture enable.
REQ-006 SHALL have port ijtag_se, input, 1, shift enable.
REQ-007 SHALL have port ijtag_ue, input, 1, update enable.
REQ-008 SHALL have port ijtag_si, input, 1, scan in.
REQ-009 SHALL have port ijtag_so, output, 1, scan out.
REQ-010 SHALL have port functional_data_in, input, WIDTH, observed functional value, captured on capture.
REQ-011 SHALL have port ijtag_data_out, output, WIDTH, registered override data driven to the data mux ijtag_data_in.
REQ-012 SHALL have port ijtag_select, output, 1, registered override select driven to the data mux ijtag_select.
REQ-013 SHALL have port ijtag_update_err, output, 1, sticky rejected-update flag.

Function
REQ-014 SHALL hold a shift register of length L = WIDTH+1 (WIDTH+2 with parity, REQ-027); bit 0 nearest ijtag_so, bit order from so: data[0..WIDTH-1], select, [parity].
REQ-015 SHALL act only when ijtag_sel=1; with ijtag_sel=0 all registers hold.
REQ-016 Capture (sel & ce) SHALL load data field with functional_data_in, select field with current ijtag_select, parity field per REQ-027, and clear the shift counter to 0.
REQ-017 Shift (sel & se & !ce) SHALL move the register one place toward bit 0, ijtag_si entering bit L-1, and increment the shift counter, saturating at its all-ones value.
REQ-018 Update (sel & ue & !ce & !se) SHALL load ijtag_data_out and ijtag_select from the shift register data/select fields, subject to REQ-028.
REQ-019 Simultaneous enables SHALL resolve by priority capture > shift > update; lower-priority actions are dropped that cycle.
REQ-020 ijtag_so SHALL equal shift-register bit 0 combinationally from the register, with no added latency.
REQ-021 Outputs ijtag_data_out/ijtag_select SHALL change only on the cycle after an accepted update; latency from ue edge to output is one cycle.
REQ-022 Shift counter width SHALL be clog2(L+2) bits; counter wrap-around is not allowed.

Reset
REQ-023 On ijtag_reset=1 at a clock edge: shift register, shift counter, ijtag_data_out, ijtag_select and ijtag_update_err SHALL become 0, overriding all enables.
REQ-024 Reset asserted mid-shift SHALL discard the partial shift; the next update without a fresh capture is governed by REQ-028 (counter 0).
REQ-025 Post-reset ijtag_select=0 SHALL guarantee the functional path through the data mux.

Configuration
REQ-026 Macro FIREBIRD7_TDR_PARITY_EN SHALL compile in integrity checking.
REQ-027 With it: L=WIDTH+2; capture loads parity field with even parity (XOR) of captured data and select fields.
REQ-028 With it: update accepted only if shift counter == L and XOR of all L shift bits == 0; else outputs hold and ijtag_update_err sets; err clears only on reset. Without it: every update accepted, parity field absent, ijtag_update_err tied 0.

Structure
REQ-029 Package firebird7_in_gate1_tessent_tdr_pkg SHALL hold WIDTH default, field-offset constants, L and counter-width constants for both configurations.
REQ-030 Sub-module firebird7_in_gate1_tessent_tdr_shift_reg SHALL implement the capture/shift register and counter; top holds update registers and check logic.

Verification
REQ-031 Reset, sel=0, toggle all enables 10 cycles -> data_out=0, select=0, so=0, err=0 throughout.
REQ-032 Capture with functional_data_in=19'h5A5A5, ijtag_select=0, then 20 shifts -> so stream LSB-first 1,0,1,0,0,1,0,1,... then select bit 0.
REQ-033 Shift in data 19'h7FFFF, select 1 (+valid parity), update -> next cycle ijtag_data_out=19'h7FFFF, ijtag_select=1.
REQ-034 ce and ue asserted same cycle -> capture occurs, outputs unchanged.
REQ-035 Parity build: shift 20 bits (one short) then update -> outputs hold, err=1; shift with corrupted parity bit -> err=1; reset -> err=0.
REQ-036 Reset asserted after 7 of 20 shifts, then update -> outputs remain 0 (parity build: err=1 only if update rejected after reset, counter=0).

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// Shared constants for the iJTAG data-override TDR: field offsets, scan length, counter width.
// FIREBIRD7_TDR_PARITY_EN adds a trailing even-parity bit to the scan chain.
package firebird7_in_gate1_tessent_tdr_pkg;

    localparam int WIDTH_DEF = 19;

`ifdef FIREBIRD7_TDR_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int DATA_OFS = 0;

    function automatic int sel_ofs(input int width);
        return width;
    endfunction

    function automatic int par_ofs(input int width);
        return width + 1;
    endfunction

    function automatic int tdr_len(input int width, input bit par);
        return par ? width + 2 : width + 1;
    endfunction

    // Two spare counts above L so a saturated counter never aliases onto L.
    function automatic int cnt_w(input int width, input bit par);
        return $clog2(tdr_len(width, par) + 2);
    endfunction

    localparam int LEN_NOPAR   = WIDTH_DEF + 1;
    localparam int LEN_PAR     = WIDTH_DEF + 2;
    localparam int CNT_W_NOPAR = $clog2(LEN_NOPAR + 2);
    localparam int CNT_W_PAR   = $clog2(LEN_PAR + 2);

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_shift_reg.sv
// Capture/shift register with a saturating shift counter; bit 0 drives scan out.
// Capture wins over shift; all state holds while the TDR is not selected.
module firebird7_in_gate1_tessent_tdr_shift_reg #(
    parameter int LEN   = 20,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic             ce,
    input  logic             se,
    input  logic             si,
    input  logic [LEN-1:0]   cap_vec,
    output logic [LEN-1:0]   sr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            sr  <= '0;
            cnt <= '0;
        end else if (sel) begin
            if (ce) begin
                sr  <= cap_vec;
                cnt <= '0;
            end else if (se) begin
                sr <= {si, sr[LEN-1:1]};
                if (cnt != '1)
                    cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_tdr_w19.sv
// iJTAG data-override TDR: scans override data/select into registered outputs for the data mux.
// FIREBIRD7_TDR_PARITY_EN enables length/parity checking of updates with a sticky error flag.
module firebird7_in_gate1_tessent_data_tdr_w19
    import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] functional_data_in,
    output logic [WIDTH-1:0] ijtag_data_out,
    output logic             ijtag_select,
    output logic             ijtag_update_err
);

    localparam int LEN   = tdr_len(WIDTH, PARITY_EN);
    localparam int CNT_W = cnt_w(WIDTH, PARITY_EN);
    localparam int SEL_O = sel_ofs(WIDTH);

    logic [LEN-1:0]   cap_vec;
    logic [LEN-1:0]   sr;
    logic [CNT_W-1:0] cnt;
    logic             do_update;
    logic             update_ok;

    always_comb begin
        cap_vec                          = '0;
        cap_vec[DATA_OFS +: WIDTH]       = functional_data_in;
        cap_vec[SEL_O]                   = ijtag_select;
`ifdef FIREBIRD7_TDR_PARITY_EN
        cap_vec[par_ofs(WIDTH)]          = ^{ijtag_select, functional_data_in};
`endif
    end

    firebird7_in_gate1_tessent_tdr_shift_reg #(
        .LEN   (LEN),
        .CNT_W (CNT_W)
    ) u_shift_reg (
        .clk     (ijtag_tck),
        .reset   (ijtag_reset),
        .sel     (ijtag_sel),
        .ce      (ijtag_ce),
        .se      (ijtag_se),
        .si      (ijtag_si),
        .cap_vec (cap_vec),
        .sr      (sr),
        .cnt     (cnt)
    );

    assign ijtag_so  = sr[0];
    assign do_update = ijtag_sel & ijtag_ue & ~ijtag_ce & ~ijtag_se;

`ifdef FIREBIRD7_TDR_PARITY_EN
    // Accept only a complete, parity-clean scan since the last capture.
    assign update_ok = (cnt == CNT_W'(LEN)) && !(^sr);

    logic update_err;

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset)
            update_err <= 1'b0;
        else if (do_update && !update_ok)
            update_err <= 1'b1;
    end

    assign ijtag_update_err = update_err;
`else
    logic unused_cnt;

    assign update_ok        = 1'b1;
    assign unused_cnt       = ^cnt;
    assign ijtag_update_err = 1'b0;
`endif

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            ijtag_data_out <= '0;
            ijtag_select   <= 1'b0;
        end else if (do_update && update_ok) begin
            ijtag_data_out <= sr[DATA_OFS +: WIDTH];
            ijtag_select   <= sr[SEL_O];
        end
    end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_tdr_w19.sv
// Scoreboard bench for the data-override TDR: captured scan-out bits are queued at capture
// and popped as each bit reaches ijtag_so; override outputs are compared against a bench model.
module tb_firebird7_in_gate1_tessent_data_tdr_w19;

    localparam int WIDTH = 19;
`ifdef FIREBIRD7_TDR_PARITY_EN
    localparam int L   = WIDTH + 2;
    localparam bit PAR = 1'b1;
`else
    localparam int L   = WIDTH + 1;
    localparam bit PAR = 1'b0;
`endif

    logic             ijtag_tck = 1'b0;
    logic             ijtag_reset;
    logic             ijtag_sel;
    logic             ijtag_ce;
    logic             ijtag_se;
    logic             ijtag_ue;
    logic             ijtag_si;
    logic             ijtag_so;
    logic [WIDTH-1:0] functional_data_in;
    logic [WIDTH-1:0] ijtag_data_out;
    logic             ijtag_select;
    logic             ijtag_update_err;

    firebird7_in_gate1_tessent_data_tdr_w19 #(.WIDTH(WIDTH)) dut (
        .ijtag_tck          (ijtag_tck),
        .ijtag_reset        (ijtag_reset),
        .ijtag_sel          (ijtag_sel),
        .ijtag_ce           (ijtag_ce),
        .ijtag_se           (ijtag_se),
        .ijtag_ue           (ijtag_ue),
        .ijtag_si           (ijtag_si),
        .ijtag_so           (ijtag_so),
        .functional_data_in (functional_data_in),
        .ijtag_data_out     (ijtag_data_out),
        .ijtag_select       (ijtag_select),
        .ijtag_update_err   (ijtag_update_err)
    );

    always #5 ijtag_tck = ~ijtag_tck;

    int               vectors     = 0;
    int               miscompares = 0;
    logic             so_q[$];
    logic [WIDTH-1:0] exp_data;
    logic             exp_sel;
    logic             exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] make_vec(input logic [WIDTH-1:0] d, input logic s);
        logic [31:0] v;
        v           = '0;
        v[WIDTH-1:0] = d;
        v[WIDTH]    = s;
        if (PAR)
            v[WIDTH+1] = ^{s, d};
        return v;
    endfunction

    task automatic cyc();
        @(posedge ijtag_tck);
        #1;
    endtask

    task automatic chk_out(input string tag);
        check({tag, "_data"}, 32'(ijtag_data_out), 32'(exp_data));
        check({tag, "_sel"},  32'(ijtag_select),   32'(exp_sel));
        check({tag, "_err"},  32'(ijtag_update_err), 32'(exp_err));
    endtask

    task automatic do_reset();
        ijtag_reset = 1'b1;
        ijtag_sel   = 1'b1;
        ijtag_ce    = 1'b1;
        ijtag_se    = 1'b1;
        ijtag_ue    = 1'b1;
        cyc();
        ijtag_reset = 1'b0;
        ijtag_ce    = 1'b0;
        ijtag_se    = 1'b0;
        ijtag_ue    = 1'b0;
        exp_data    = '0;
        exp_sel     = 1'b0;
        exp_err     = 1'b0;
        so_q.delete();
    endtask

    task automatic capture(input logic [WIDTH-1:0] d);
        logic [31:0] v;
        v = make_vec(d, exp_sel);
        functional_data_in = d;
        ijtag_ce = 1'b1;
        cyc();
        ijtag_ce = 1'b0;
        so_q.delete();
        for (int i = 0; i < L; i++)
            so_q.push_back(v[i]);
    endtask

    task automatic shift(input logic [31:0] vin, input int n);
        for (int i = 0; i < n; i++) begin
            ijtag_si = vin[i];
            if (so_q.size() > 0)
                check("so", 32'(ijtag_so), 32'(so_q.pop_front()));
            ijtag_se = 1'b1;
            cyc();
        end
        ijtag_se = 1'b0;
    endtask

    task automatic update();
        ijtag_ue = 1'b1;
        cyc();
        ijtag_ue = 1'b0;
    endtask

    initial begin
        ijtag_sel = 1'b0; ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0;
        ijtag_si = 1'b0; ijtag_reset = 1'b0; functional_data_in = '0;
        do_reset();
        check("rst_so", 32'(ijtag_so), 32'h0);
        chk_out("rst");

        // Deselected: any enable activity must leave everything at zero.
        ijtag_sel = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ijtag_ce = 1'($urandom_range(0, 1));
            ijtag_se = 1'($urandom_range(0, 1));
            ijtag_ue = 1'($urandom_range(0, 1));
            ijtag_si = 1'($urandom_range(0, 1));
            functional_data_in = WIDTH'($urandom);
            cyc();
            check("nosel_so", 32'(ijtag_so), 32'h0);
            chk_out("nosel");
        end
        ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0;
        ijtag_sel = 1'b1;

        // Capture 5A5A5 and shift it out while shifting in 7FFFF/select=1.
        capture(19'h5A5A5);
        shift(make_vec(19'h7FFFF, 1'b1), L);
        chk_out("preupd");
        update();
        exp_data = 19'h7FFFF; exp_sel = 1'b1;
        chk_out("upd1");

        // ce and ue together: capture only, outputs untouched.
        functional_data_in = 19'h12345;
        ijtag_ce = 1'b1; ijtag_ue = 1'b1;
        cyc();
        ijtag_ce = 1'b0; ijtag_ue = 1'b0;
        chk_out("ce_ue");
        begin
            logic [31:0] v;
            v = make_vec(19'h12345, exp_sel);
            for (int i = 0; i < L; i++)
                so_q.push_back(v[i]);
        end
        shift(make_vec(19'h2A5C3, 1'b0), L);
        update();
        exp_data = 19'h2A5C3; exp_sel = 1'b0;
        chk_out("upd2");

        // se and ue together: shift only, outputs untouched; then deselected update ignored.
        capture(19'h0F0F0);
        shift(make_vec(19'h11111, 1'b1), L);
        ijtag_se = 1'b1; ijtag_ue = 1'b1; ijtag_si = 1'b0;
        cyc();
        ijtag_se = 1'b0; ijtag_ue = 1'b0;
        chk_out("se_ue");
        ijtag_sel = 1'b0; ijtag_ue = 1'b1;
        cyc();
        ijtag_sel = 1'b1; ijtag_ue = 1'b0;
        chk_out("nosel_ue");

`ifdef FIREBIRD7_TDR_PARITY_EN
        // One shift short: rejected, sticky error.
        capture(19'h3C3C3);
        shift(make_vec(19'h01234, 1'b1), L - 1);
        update();
        exp_err = 1'b1;
        chk_out("short");
        cyc();
        chk_out("sticky");
        do_reset();
        chk_out("err_rst");
        // Corrupted parity bit: rejected.
        capture(19'h3C3C3);
        shift(make_vec(19'h04321, 1'b0) ^ (32'h1 << (WIDTH + 1)), L);
        update();
        exp_err = 1'b1;
        chk_out("badpar");
        do_reset();
        chk_out("badpar_rst");
`else
        capture(19'h3C3C3);
        shift(make_vec(19'h04321, 1'b0), L);
        update();
        exp_data = 19'h04321; exp_sel = 1'b0;
        chk_out("upd3");
        do_reset();
        chk_out("upd3_rst");
`endif

        // Reset after 7 shifts discards the partial scan.
        capture(19'h55555);
        shift(make_vec(19'h7ABCD, 1'b1), 7);
        do_reset();
        check("midrst_so", 32'(ijtag_so), 32'h0);
        update();
        exp_err = PAR;
        chk_out("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
